fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Issue controller and scheduler for the floating-point execution units. It sits between decode and the FP datapath, and receives FP exec_type codes EFadd..EItof.
- Sequences unit starts and enforces operand hazards through a pending-register scoreboard.
- Shares the single iterative div/sqrt unit between requests.
- Reserves the single FP writeback port cycle-exactly, so no two units ever write back in the same cycle.

Parameters:
- ADD_LAT, 3, cycles from start to writeback for EFadd/EFsub
- MUL_LAT, 2, cycles from start to writeback for EFmul
- CVT_LAT, 1, cycles from start to writeback for EFtoi/EItof
- DIV_LAT, 12, cycles from start to writeback for EFdiv (iterative, not pipelined)
- SQRT_LAT, 10, cycles from start to writeback for EFsqrt (shares the div unit)
- WB_DEPTH, 16, writeback reservation window in cycles; must be >= max latency + 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presents an FP op
- issue_ready  out  1  op accepted this cycle when high together with issue_valid
- issue_op  in  4  exec_type code
- issue_rd  in  5  destination FP register
- issue_rs1  in  5  source 1 FP register
- issue_rs2  in  5  source 2 FP register
- issue_use_rs2  in  1  rs2 is a real operand
- start  out  1  registered one-cycle start pulse to the selected unit
- start_op  out  4  exec_type code of the started op
- divsq_busy  out  1  iterative div/sqrt unit occupied
- wb_valid  out  1  writeback mux selects a unit result this cycle
- wb_op  out  4  exec_type code being written back
- wb_rd  out  5  destination register of this writeback
- pending  out  32  scoreboard; bit r set while register r awaits a writeback
- err_illegal  out  1  one-cycle pulse when a non-FP code is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: start=0, start_op=0, divsq_busy=0, wb_valid=0, wb_op=0, wb_rd=0, pending=0, err_illegal=0. The reservation window and the div FSM are cleared. A reset mid-operation discards all in-flight tracking; the FP units are reset by the same rst.
- Latency L(op) is selected by parameter per op, as listed above.
- Accept in cycle t:
  - start=1 and start_op=issue_op in cycle t+1.
  - wb_valid=1 with that op and rd in exactly cycle t+1+L.
  - pending[rd] is set from cycle t+1 through cycle t+1+L inclusive, and cleared at the end of the writeback cycle.
- issue_ready is combinational from state and the issue_* inputs. It is low, and the op stalls, if any of the following holds:
  - (a) RAW: pending[rs1], or issue_use_rs2 and pending[rs2].
  - (b) WAW: pending[rd].
  - (c) Writeback conflict: cycle t+1+L is already reserved.
  - (d) Structural: op is EFdiv or EFsqrt and the div unit cannot start in cycle t+1.
- Reservation window: WB_DEPTH-entry shift register of {valid, op, rd}, advanced every cycle. Entry 0 drives wb_valid, wb_op and wb_rd (all registered).
- Div FSM, two states:
  - DS_IDLE -> DS_BUSY on start of EFdiv or EFsqrt.
  - In DS_BUSY, a down-counter loaded with L-1 counts to 0, then the FSM returns to DS_IDLE.
  - divsq_busy=1 while in DS_BUSY.
  - A new div/sqrt may be accepted in the last busy cycle (counter=0), so starts can be back-to-back at an L-cycle spacing.
- Pipelined units (add, mul, cvt) accept one op per cycle, subject to (a) through (c) only.
- Illegal codes (not in 7..13) are accepted immediately with issue_ready=1: err_illegal=1 next cycle, no start, no reservation, no scoreboard change.
- Simultaneous events: a writeback and an accept may occur in the same cycle; the clear and the set of pending apply to different registers, guaranteed by the WAW rule.
- issue_valid=0 produces no state change except the window shift.

Optional Feature:
- Macro: FPU_WB_FWD_EN.
- When defined: rule (a) ignores a source register whose writeback occurs in the current cycle (wb_valid && wb_rd==rs); the datapath forwards from the writeback bus, so the op is accepted that cycle.
- When undefined: such an op stalls until the cycle after the writeback.
- WAW handling is identical in both builds.

Test Plan:
- EFadd rd=3 accepted at cycle 0 -> start/start_op=7 at cycle 1; wb_valid with wb_rd=3 at cycle 4; pending[3]=1 in cycles 1..4, 0 at cycle 5.
- EFadd rd=1 at cycle 0, then EFmul rd=2 presented at cycle 1 (writeback slot 4 collides) -> ready=0 at cycle 1; accepted at cycle 2; writebacks rd=1 at cycle 4, rd=2 at cycle 5.
- EFdiv rd=4 at cycle 0, then EFsqrt rd=6 held valid -> divsq_busy cycles 1..12; sqrt accepted at cycle 12; start at cycle 13; writebacks at cycles 13 and 23.
- EFmul rd=5 at cycle 0, then EFadd rs1=5 held valid -> accepted at cycle 4 without the macro, cycle 3 with FPU_WB_FWD_EN.
- issue_op=1 (EAdd) valid -> accepted at once, err_illegal pulse next cycle, no start, pending unchanged.
- EFdiv accepted, rst asserted at cycle 5 -> outputs zero asynchronously, no wb_valid afterward, a new EFdiv is accepted the first cycle after release.

Source files
------------

// File: rtl/fpu_issue_ctrl_if.sv
// Decode-side issue handshake and FP-datapath control/status bundle for fpu_issue_ctrl.
interface fpu_issue_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs2;
  logic        start;
  logic [3:0]  start_op;
  logic        divsq_busy;
  logic        wb_valid;
  logic [3:0]  wb_op;
  logic [4:0]  wb_rd;
  logic [31:0] pending;
  logic        err_illegal;

  modport slave (
    input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_use_rs2,
    output issue_ready, start, start_op, divsq_busy, wb_valid, wb_op, wb_rd,
           pending, err_illegal
  );

  modport master (
    output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_use_rs2,
    input  issue_ready, start, start_op, divsq_busy, wb_valid, wb_op, wb_rd,
           pending, err_illegal
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: scoreboard hazards, shared div/sqrt sequencing, cycle-exact writeback slots.
// Optional FPU_WB_FWD_EN lets a source read bypass from the writeback bus in its writeback cycle.
module fpu_issue_ctrl #(
  parameter int ADD_LAT  = 3,
  parameter int MUL_LAT  = 2,
  parameter int CVT_LAT  = 1,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 10,
  parameter int WB_DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  fpu_issue_if.slave io
);
  localparam logic [3:0] EFADD = 4'd7, EFSUB = 4'd8, EFMUL = 4'd9, EFDIV = 4'd10;
  localparam logic [3:0] EFSQRT = 4'd11, EFTOI = 4'd12, EITOF = 4'd13;
  localparam int IW = $clog2(WB_DEPTH);
  localparam int CW = 8;
  localparam logic [0:0] DS_IDLE = 1'b0, DS_BUSY = 1'b1;

  typedef struct packed {
    logic       vld;
    logic [3:0] op;
    logic [4:0] rd;
  } wb_slot_t;

  wb_slot_t [WB_DEPTH-1:0] r_win, w_win_nxt;
  logic [31:0]   r_pending, w_src_pend, w_clr, w_set;
  logic          r_start, r_err;
  logic [3:0]    r_start_op;
  logic [0:0]    r_ds_state;
  logic [CW-1:0] r_ds_cnt, w_ds_ld;
  logic [IW-1:0] w_lat;
  logic          w_legal, w_is_ds, w_raw, w_waw, w_wbc, w_ds_blk, w_ready, w_acc, w_acc_fp;

  assign w_legal = (io.issue_op >= EFADD) && (io.issue_op <= EITOF);
  assign w_is_ds = (io.issue_op == EFDIV) || (io.issue_op == EFSQRT);

  always_comb begin
    w_lat = '0;
    case (io.issue_op)
      EFADD, EFSUB: w_lat = IW'(ADD_LAT);
      EFMUL:        w_lat = IW'(MUL_LAT);
      EFDIV:        w_lat = IW'(DIV_LAT);
      EFSQRT:       w_lat = IW'(SQRT_LAT);
      EFTOI, EITOF: w_lat = IW'(CVT_LAT);
      default:      w_lat = '0;
    endcase
  end

  assign w_clr = r_win[0].vld ? (32'd1 << r_win[0].rd) : 32'd0;
`ifdef FPU_WB_FWD_EN
  // The register being written this cycle is readable off the writeback bus.
  assign w_src_pend = r_pending & ~w_clr;
`else
  assign w_src_pend = r_pending;
`endif

  assign w_raw    = w_src_pend[io.issue_rs1] | (io.issue_use_rs2 & w_src_pend[io.issue_rs2]);
  assign w_waw    = r_pending[io.issue_rd];
  // Slot k of the window is written back k cycles from now; a start next cycle lands at lat+1.
  assign w_wbc    = r_win[w_lat + IW'(1)].vld;
  assign w_ds_blk = w_is_ds & (r_ds_state == DS_BUSY) & (r_ds_cnt != '0);
  assign w_ready  = ~w_legal | ~(w_raw | w_waw | w_wbc | w_ds_blk);
  assign w_acc    = io.issue_valid & w_ready;
  assign w_acc_fp = w_acc & w_legal;
  assign w_set    = w_acc_fp ? (32'd1 << io.issue_rd) : 32'd0;
  assign w_ds_ld  = (io.issue_op == EFDIV) ? CW'(DIV_LAT - 1) : CW'(SQRT_LAT - 1);

  always_comb begin
    for (int k = 0; k < WB_DEPTH - 1; k++) w_win_nxt[k] = r_win[k+1];
    w_win_nxt[WB_DEPTH-1] = '0;
    if (w_acc_fp) w_win_nxt[w_lat] = '{vld: 1'b1, op: io.issue_op, rd: io.issue_rd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win      <= '0;
      r_pending  <= '0;
      r_start    <= 1'b0;
      r_start_op <= '0;
      r_err      <= 1'b0;
    end else begin
      r_win     <= w_win_nxt;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_start   <= w_acc_fp;
      r_err     <= w_acc & ~w_legal;
      if (w_acc_fp) r_start_op <= io.issue_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ds_state <= DS_IDLE;
      r_ds_cnt   <= '0;
    end else begin
      case (r_ds_state)
        DS_IDLE: if (w_acc_fp && w_is_ds) begin
          r_ds_state <= DS_BUSY;
          r_ds_cnt   <= w_ds_ld;
        end
        default: if (r_ds_cnt != '0) begin
          r_ds_cnt <= r_ds_cnt - CW'(1);
        end else if (w_acc_fp && w_is_ds) begin
          r_ds_cnt <= w_ds_ld;
        end else begin
          r_ds_state <= DS_IDLE;
        end
      endcase
    end
  end

  assign io.issue_ready = w_ready;
  assign io.start       = r_start;
  assign io.start_op    = r_start_op;
  assign io.divsq_busy  = (r_ds_state == DS_BUSY);
  assign io.wb_valid    = r_win[0].vld;
  assign io.wb_op       = r_win[0].op;
  assign io.wb_rd       = r_win[0].rd;
  assign io.pending     = r_pending;
  assign io.err_illegal = r_err;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_fpu_issue_ctrl;
  localparam int ADD_LAT = 3, MUL_LAT = 2, CVT_LAT = 1, DIV_LAT = 12, SQRT_LAT = 10, WB_DEPTH = 16;
`ifdef FPU_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_issue_if bus();

  fpu_issue_ctrl #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .CVT_LAT(CVT_LAT),
    .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int checks = 0, failures = 0;
  int cyc = 0;

  // Model: absolute-cycle timeline of starts, writebacks, error pulses and pending intervals.
  int pfrom[32], puntil[32];
  int wbq[int];
  int stq[int];
  int errq[int];
  int busy_from, busy_to, div_next;

  function automatic int lat(input int op);
    case (op)
      7, 8:    return ADD_LAT;
      9:       return MUL_LAT;
      10:      return DIV_LAT;
      11:      return SQRT_LAT;
      12, 13:  return CVT_LAT;
      default: return 0;
    endcase
  endfunction

  function automatic bit pend(input int r);
    return (pfrom[r] <= cyc) && (cyc <= puntil[r]);
  endfunction

  function automatic bit src_pend(input int r);
    bit byp;
    byp = FWD && wbq.exists(cyc) && ((wbq[cyc] % 32) == r);
    return pend(r) && !byp;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      pfrom[r]  = 1;
      puntil[r] = 0;
    end
    wbq.delete();
    stq.delete();
    errq.delete();
    busy_from = 1;
    busy_to   = 0;
    div_next  = -1;
  endtask

  task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                      input bit u, output bit acc);
    bit legal, er, ds;
    logic [31:0] pv;
    int L;
    bus.issue_valid   = v;
    bus.issue_op      = 4'(op);
    bus.issue_rd      = 5'(rd);
    bus.issue_rs1     = 5'(rs1);
    bus.issue_rs2     = 5'(rs2);
    bus.issue_use_rs2 = u;
    @(negedge clk);
    legal = (op >= 7) && (op <= 13);
    ds    = (op == 10) || (op == 11);
    L     = lat(op);
    if (!legal) er = 1'b1;
    else er = !(src_pend(rs1) || (u && src_pend(rs2)) || pend(rd) ||
                wbq.exists(cyc + 1 + L) || (ds && cyc < div_next));
    pv = '0;
    for (int r = 0; r < 32; r++) pv[r] = pend(r);
    chk("issue_ready", 32'(bus.issue_ready), 32'(er));
    chk("start", 32'(bus.start), 32'(stq.exists(cyc)));
    if (stq.exists(cyc)) chk("start_op", 32'(bus.start_op), 32'(stq[cyc]));
    chk("wb_valid", 32'(bus.wb_valid), 32'(wbq.exists(cyc)));
    if (wbq.exists(cyc)) begin
      chk("wb_op", 32'(bus.wb_op), 32'(wbq[cyc] / 32));
      chk("wb_rd", 32'(bus.wb_rd), 32'(wbq[cyc] % 32));
    end
    chk("pending", bus.pending, pv);
    chk("divsq_busy", 32'(bus.divsq_busy), 32'((busy_from <= cyc) && (cyc <= busy_to)));
    chk("err_illegal", 32'(bus.err_illegal), 32'(errq.exists(cyc)));
    acc = v && er;
    if (acc) begin
      if (legal) begin
        stq[cyc+1]      = op;
        wbq[cyc+1+L]    = op * 32 + rd;
        pfrom[rd]       = cyc + 1;
        puntil[rd]      = cyc + 1 + L;
        if (ds) begin
          busy_from = cyc + 1;
          busy_to   = cyc + L;
          div_next  = cyc + L;
        end
      end else begin
        errq[cyc+1] = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0, a);
  endtask

  // Hold an op valid until accepted; at = acceptance cycle or -1 if the bound expires.
  task automatic wait_acc(input int op, input int rd, input int rs1, input int rs2, input bit u,
                          input int maxn, output int at);
    bit a;
    at = -1;
    for (int i = 0; i < maxn; i++) begin
      step(1'b1, op, rd, rs1, rs2, u, a);
      if (a) begin
        at = cyc - 1;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"},    32'(bus.start),       32'd0);
    chk({tag, "_start_op"}, 32'(bus.start_op),    32'd0);
    chk({tag, "_busy"},     32'(bus.divsq_busy),  32'd0);
    chk({tag, "_wbv"},      32'(bus.wb_valid),    32'd0);
    chk({tag, "_wbop"},     32'(bus.wb_op),       32'd0);
    chk({tag, "_wbrd"},     32'(bus.wb_rd),       32'd0);
    chk({tag, "_pending"},  bus.pending,          32'd0);
    chk({tag, "_err"},      32'(bus.err_illegal), 32'd0);
  endtask

  initial begin
    int t0, at;
    bit a;
    rst = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_rd = '0;
    bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_use_rs2 = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_zero("reset");
    rst = 1'b0;
    cyc = 0;
    drain(2);

    // Single add: start next cycle, writeback 4 cycles after acceptance.
    t0 = cyc;
    wait_acc(7, 3, 0, 0, 1'b0, 4, at);
    chk("s1_acc", 32'(at - t0), 32'd0);
    drain(6);

    // Mul colliding with the add's writeback slot stalls one cycle.
    t0 = cyc;
    step(1'b1, 7, 1, 10, 11, 1'b1, a);
    chk("s2_add_acc", 32'(a), 32'd1);
    wait_acc(9, 2, 10, 11, 1'b1, 8, at);
    chk("s2_mul_acc", 32'(at - t0), 32'd2);
    drain(6);

    // Div then sqrt: sqrt accepted in the div's last busy cycle.
    t0 = cyc;
    step(1'b1, 10, 4, 12, 13, 1'b1, a);
    chk("s3_div_acc", 32'(a), 32'd1);
    wait_acc(11, 6, 12, 0, 1'b0, 20, at);
    chk("s3_sqrt_acc", 32'(at - t0), 32'd12);
    drain(14);

    // RAW on a mul result; forwarding saves one cycle.
    t0 = cyc;
    step(1'b1, 9, 5, 0, 0, 1'b0, a);
    chk("s4_mul_acc", 32'(a), 32'd1);
    wait_acc(7, 7, 5, 0, 1'b0, 8, at);
    chk("s4_raw_acc", 32'(at - t0), FWD ? 32'd3 : 32'd4);
    drain(5);

    // Illegal code: immediate accept, error pulse, nothing else.
    t0 = cyc;
    wait_acc(1, 3, 0, 0, 1'b0, 2, at);
    chk("s5_illegal_acc", 32'(at - t0), 32'd0);
    drain(2);

    // Reset in the middle of a div.
    t0 = cyc;
    step(1'b1, 10, 4, 0, 0, 1'b0, a);
    chk("s6_div_acc", 32'(a), 32'd1);
    drain(4);
    #1 rst = 1'b1;
    #1 chk_zero("s6_async");
    @(posedge clk); cyc++;
    @(posedge clk); cyc++; #1;
    chk_zero("s6_held");
    rst = 1'b0;
    model_reset();
    t0 = cyc;
    wait_acc(10, 4, 0, 0, 1'b0, 1, at);
    chk("s6_div_after_rst", 32'(at - t0), 32'd0);
    drain(16);

    // Random traffic over a small register set to provoke every hazard.
    for (int i = 0; i < 600; i++) begin
      int op;
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(7, 13)) : int'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, op, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)), a);
    end
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
